// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch block
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Cycles between imem_rd and the matching imem_rdata
    localparam int IMEM_LATENCY = 1;

    // Program counter value after reset
    localparam int RESET_PC = 0;

endpackage

// File: rtl/instr_buf.sv
// instr_buf: synchronous FIFO holding fetched instruction words
module instr_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    rd,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_rd;

    // Reading an empty buffer is ignored so the pointers never run ahead
    assign w_rd  = rd && !empty;
    assign rdata = r_mem[r_rp];
    assign count = r_cnt;
    assign empty = (r_cnt == '0);

    // Pointer and occupancy update; a clear dominates write and read
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (wr)
                r_wp <= r_wp + 1'b1;
            if (w_rd)
                r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(wr) - CW'(w_rd);
        end
    end

    // Data storage; contents are meaningless while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (wr && !clr && !rst)
            r_mem[r_wp] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencer issuing instruction memory reads into a small buffer
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int WIDTH_INSTR = 16,
    parameter int WIDTH_JDATA = 24,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    output logic                   imem_rd,
    output logic [WIDTH_JDATA-1:0] imem_addr,
    input  logic [WIDTH_INSTR-1:0] imem_rdata,
    output logic [WIDTH_INSTR-1:0] instr,
    output logic                   valid,
    input  logic                   next_instr,
    input  logic                   jump,
    input  logic [WIDTH_JDATA-1:0] jdata,
    output logic                   exe_flush,
    output logic                   busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WIDTH_JDATA-1:0]  r_pc;
    logic [IMEM_LATENCY-1:0] r_pend;
    logic                    r_flush;
    logic [CW-1:0]           w_count;
    logic [WIDTH_INSTR-1:0]  w_head;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_ret;
    logic                    w_issue;

    assign w_pop = next_instr && !w_empty;
    assign w_ret = r_pend[IMEM_LATENCY-1];

    // Credit rule: buffered words plus reads in flight, less this cycle's pop,
    // must leave room, so a returning word always finds a free slot
    assign w_issue = (r_state == RUN) && !jump &&
                     (int'(w_count) + $countones(r_pend) - int'(w_pop) < DEPTH);

    assign imem_rd   = w_issue;
    assign imem_addr = r_pc;
    assign valid     = !w_empty;
    assign instr     = w_empty ? '0 : w_head;
    assign exe_flush = r_flush;
    assign busy      = (r_state != IDLE);

    // Next-state selection for the IDLE/RUN/DRAIN sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? RUN : IDLE;
            RUN:     w_state_nxt = halt ? DRAIN : RUN;
            DRAIN:   w_state_nxt = (w_empty && r_pend == '0) ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, PC, in-flight tracking and flush pulse; a jump overrides issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= WIDTH_JDATA'(RESET_PC);
            r_pend  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= jump ? jdata : r_pc + WIDTH_JDATA'(w_issue);
            r_pend  <= jump ? '0 : (r_pend << 1) | IMEM_LATENCY'(w_issue);
            r_flush <= jump && (r_state != IDLE);
        end
    end

    instr_buf #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH_INSTR)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (jump),
        .wr    (w_ret),
        .wdata (imem_rdata),
        .rd    (w_pop),
        .rdata (w_head),
        .count (w_count),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector bench for the instruction fetch sequencer
module tb_instr_fetch;

    typedef struct {
        logic [3:0]  ctl;
        logic [23:0] jd;
        logic [23:0] ad;
        logic [15:0] ins;
        logic [3:0]  flg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        next_instr = 1'b0;
    logic        jump = 1'b0;
    logic [23:0] jdata = 24'h0;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_rd;
    logic [23:0] imem_addr;
    logic [15:0] instr;
    logic        valid;
    logic        exe_flush;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   occ = 0;
    logic pend = 1'b0;
    vec_t tbl [8];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .valid      (valid),
        .next_instr (next_instr),
        .jump       (jump),
        .jdata      (jdata),
        .exe_flush  (exe_flush),
        .busy       (busy)
    );

    // Instruction memory: 1-cycle latency, word = 0x1000 + address
    always @(posedge clk) begin
        if (imem_rd)
            imem_rdata <= 16'h1000 + imem_addr[15:0];
    end

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Occupancy scoreboard: words written a cycle after each read, minus pops
    always @(negedge clk) begin
        if (!rst) begin
            chk("occ_valid", 24'(valid), 24'(occ != 0));
            checks++;
            if (occ > 2) begin
                errors++;
                $display("FAIL overflow occ %0d max 2", occ);
            end
        end
        occ  = (rst || jump) ? 0 : occ + int'(pend) - int'(next_instr && valid);
        pend = !rst && imem_rd;
    end

    function automatic vec_t v(input logic [3:0] ctl, input logic [23:0] jd,
                               input logic [23:0] ad, input logic [15:0] ins,
                               input logic [3:0] flg);
        vec_t r;
        r.ctl = ctl;
        r.jd  = jd;
        r.ad  = ad;
        r.ins = ins;
        r.flg = flg;
        return r;
    endfunction

    // ctl = {start, halt, next_instr, jump}; flg = {imem_rd, valid, exe_flush, busy}
    task automatic apply(input string tag, input vec_t x);
        {start, halt, next_instr, jump} = x.ctl;
        jdata = x.jd;
        @(negedge clk);
        chk({tag, ".rd"},    24'(imem_rd),   24'(x.flg[3]));
        chk({tag, ".addr"},  imem_addr,      x.ad);
        chk({tag, ".valid"}, 24'(valid),     24'(x.flg[2]));
        chk({tag, ".instr"}, 24'(instr),     24'(x.ins));
        chk({tag, ".flush"}, 24'(exe_flush), 24'(x.flg[1]));
        chk({tag, ".busy"},  24'(busy),      24'(x.flg[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {start, halt, next_instr, jump} = 4'b0000;
        jdata = 24'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = v(4'b1010, 24'h0, 24'h0, 16'h0000, 4'b0000);
        tbl[1] = v(4'b0010, 24'h0, 24'h0, 16'h0000, 4'b1001);
        tbl[2] = v(4'b0010, 24'h0, 24'h1, 16'h0000, 4'b1001);
        tbl[3] = v(4'b0010, 24'h0, 24'h2, 16'h1000, 4'b1101);
        tbl[4] = v(4'b0010, 24'h0, 24'h3, 16'h1001, 4'b1101);
        tbl[5] = v(4'b0010, 24'h0, 24'h4, 16'h1002, 4'b1101);
        tbl[6] = v(4'b0010, 24'h0, 24'h5, 16'h1003, 4'b1101);
        tbl[7] = v(4'b0010, 24'h0, 24'h6, 16'h1004, 4'b1101);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rd",    24'(imem_rd),   24'(1'b0));
        chk("rst.addr",  imem_addr,      24'h0);
        chk("rst.valid", 24'(valid),     24'(1'b0));
        chk("rst.instr", 24'(instr),     24'h0);
        chk("rst.flush", 24'(exe_flush), 24'(1'b0));
        chk("rst.busy",  24'(busy),      24'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            apply($sformatf("stream[%0d]", i), tbl[i]);

        do_reset();
        apply("stall0", v(4'b1000, 24'h0, 24'h0, 16'h0000, 4'b0000));
        apply("stall1", v(4'b0000, 24'h0, 24'h0, 16'h0000, 4'b1001));
        apply("stall2", v(4'b0000, 24'h0, 24'h1, 16'h0000, 4'b1001));
        for (int i = 3; i < 7; i++)
            apply($sformatf("stall%0d", i), v(4'b0000, 24'h0, 24'h2, 16'h1000, 4'b0101));
        apply("rel7",   v(4'b0010, 24'h0, 24'h2, 16'h1000, 4'b1101));
        apply("rel8",   v(4'b0010, 24'h0, 24'h3, 16'h1001, 4'b1101));
        apply("rel9",   v(4'b0010, 24'h0, 24'h4, 16'h1002, 4'b1101));
        apply("rel10",  v(4'b0010, 24'h0, 24'h5, 16'h1003, 4'b1101));
        apply("jmp11",  v(4'b0001, 24'h40, 24'h6, 16'h1004, 4'b0101));
        apply("jmp12",  v(4'b0000, 24'h0, 24'h40, 16'h0000, 4'b1011));
        apply("jmp13",  v(4'b0000, 24'h0, 24'h41, 16'h0000, 4'b1001));
        apply("jmp14",  v(4'b0000, 24'h0, 24'h42, 16'h1040, 4'b0101));
        apply("jmp15",  v(4'b0010, 24'h0, 24'h42, 16'h1040, 4'b1101));
        apply("jj16",   v(4'b0011, 24'h100, 24'h43, 16'h1041, 4'b0101));
        apply("jj17",   v(4'b0011, 24'h200, 24'h100, 16'h0000, 4'b0011));
        apply("jj18",   v(4'b0010, 24'h0, 24'h200, 16'h0000, 4'b1011));
        apply("jj19",   v(4'b0010, 24'h0, 24'h201, 16'h0000, 4'b1001));
        apply("jj20",   v(4'b0010, 24'h0, 24'h202, 16'h1200, 4'b1101));

        do_reset();
        apply("wrap0", v(4'b0001, 24'hFFFFFF, 24'h0, 16'h0000, 4'b0000));
        apply("wrap1", v(4'b1000, 24'h0, 24'hFFFFFF, 16'h0000, 4'b0000));
        apply("wrap2", v(4'b0010, 24'h0, 24'hFFFFFF, 16'h0000, 4'b1001));
        apply("wrap3", v(4'b0010, 24'h0, 24'h000000, 16'h0000, 4'b1001));
        apply("wrap4", v(4'b0010, 24'h0, 24'h000001, 16'h0FFF, 4'b1101));
        apply("wrap5", v(4'b0010, 24'h0, 24'h000002, 16'h1000, 4'b1101));

        do_reset();
        apply("halt0",  v(4'b1000, 24'h0, 24'h0, 16'h0000, 4'b0000));
        apply("halt1",  v(4'b0000, 24'h0, 24'h0, 16'h0000, 4'b1001));
        apply("halt2",  v(4'b0000, 24'h0, 24'h1, 16'h0000, 4'b1001));
        apply("halt3",  v(4'b0000, 24'h0, 24'h2, 16'h1000, 4'b0101));
        apply("halt4",  v(4'b0110, 24'h0, 24'h2, 16'h1000, 4'b1101));
        apply("halt5",  v(4'b0010, 24'h0, 24'h3, 16'h1001, 4'b0101));
        apply("halt6",  v(4'b1010, 24'h0, 24'h3, 16'h1002, 4'b0101));
        apply("halt7",  v(4'b1010, 24'h0, 24'h3, 16'h0000, 4'b0001));
        apply("halt8",  v(4'b1110, 24'h0, 24'h3, 16'h0000, 4'b0000));
        apply("halt9",  v(4'b0010, 24'h0, 24'h3, 16'h0000, 4'b1001));
        apply("halt10", v(4'b0010, 24'h0, 24'h4, 16'h0000, 4'b1001));
        apply("halt11", v(4'b0010, 24'h0, 24'h5, 16'h1003, 4'b1101));

        do_reset();
        apply("mrst0", v(4'b1010, 24'h0, 24'h0, 16'h0000, 4'b0000));
        apply("mrst1", v(4'b0010, 24'h0, 24'h0, 16'h0000, 4'b1001));
        apply("mrst2", v(4'b0010, 24'h0, 24'h1, 16'h0000, 4'b1001));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("mrst4", v(4'b0000, 24'h0, 24'h0, 16'h0000, 4'b0000));
        apply("mrst5", v(4'b0000, 24'h0, 24'h0, 16'h0000, 4'b0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch sequencer for the vector core.
- Owns the program counter and issues reads to the instruction memory, which has a fixed 1-cycle read latency.
- Buffers returned words in a small FIFO and presents them as instr/valid to the decode controller.
- Pops on next_instr, redirects on jump/jdata, and generates the exe_flush pulse that squashes the instruction behind a taken jump.

Parameters:
- WIDTH_INSTR, 16, instruction word width.
- WIDTH_JDATA, 24, program counter / jump target width.
- DEPTH, 2, instruction buffer entries; must be a power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; leave IDLE and begin fetching at current PC.
- halt  in  1  pulse; stop issuing, drain buffer, return to IDLE.
- imem_rd  out  1  read strobe to instruction memory.
- imem_addr  out  WIDTH_JDATA  read address (= PC when imem_rd).
- imem_rdata  in  WIDTH_INSTR  read data, valid exactly 1 cycle after imem_rd.
- instr  out  WIDTH_INSTR  buffer head to decode.
- valid  out  1  buffer non-empty.
- next_instr  in  1  pop head; ignored when valid=0.
- jump  in  1  redirect request from execute stage.
- jdata  in  WIDTH_JDATA  jump target.
- exe_flush  out  1  one-cycle squash pulse, registered.
- busy  out  1  state != IDLE.

Behaviour:
Reset (sync, rst=1 at clock edge):
- State=IDLE, PC=0, buffer empty, rd_pend=0.
- Outputs: valid=0, instr=0, imem_rd=0, imem_addr=0, exe_flush=0, busy=0.
- Reset mid-operation discards buffered words and in-flight reads; data returning the cycle after reset is not written.

States:
- IDLE -> RUN on start.
- RUN -> DRAIN on halt.
- DRAIN -> IDLE when buffer empty and rd_pend=0.
- start in DRAIN is ignored.
- halt in IDLE is ignored.

Issue (combinational):
- imem_rd = (state==RUN) && !jump && (count + rd_pend - pop < DEPTH), where pop = next_instr && valid.
- imem_addr = PC.
- On issue, PC <= PC+1, wrapping from 2^WIDTH_JDATA-1 to 0.
- rd_pend <= imem_rd.

Return:
- When rd_pend=1, imem_rdata is written to the buffer tail at the same edge.
- Simultaneous write and pop are allowed; count is unchanged.
- Overflow is impossible by the credit rule; the bench asserts this.

Latency:
- start at edge T gives imem_rd in cycle T+1.
- Data is written at the end of T+2; valid=1 in cycle T+3.
- Steady state with next_instr held high and DEPTH=2: one instruction per cycle.

Jump (priority over all other events in the same cycle):
- PC <= jdata.
- Buffer cleared; the clear wins over a simultaneous return-write and over pop.
- rd_pend <= 0; no issue in the jump cycle.
- exe_flush <= 1 for exactly the following cycle, but only if state != IDLE.
- In IDLE, jump only loads PC.
- Next issue is at jdata in cycle j+1; valid reasserts in cycle j+3.
- Jump with halt in the same cycle: redirect applies, state -> DRAIN, no new issue.
- Consecutive jumps: last target wins; exe_flush stays high each following cycle.

Other rules:
- instr holds the head entry when valid=1 and is 0 when valid=0.
- busy = (state != IDLE).

Decomposition:
- Package fetch_pkg holds:
  - the state enum {IDLE, RUN, DRAIN}, 2 bits;
  - IMEM_LATENCY=1;
  - reset-PC constant 0.
- One sub-module, instr_buf: synchronous FIFO, DEPTH x WIDTH_INSTR.
  - Ports: clk, rst, clr, wr, wdata, rd, rdata, count, empty.
  - clr has priority over wr and rd.
- Sequencer, PC and credit logic stay in instr_fetch.

Test Plan:
- Reset, start, imem returns 0x1000+addr, next_instr=1 constantly:
  - imem_rd rises 1 cycle after start;
  - valid rises 3 cycles after start;
  - instr sequence 0x1000, 0x1001, ... with no bubbles;
  - imem_addr 0, 1, 2, ...
- next_instr=0 for 6 cycles after fetch starts:
  - issues stop after 2 reads (count=2, imem_rd=0);
  - on release, instr 0x1000, 0x1001, 0x1002 in order;
  - no loss or duplication.
- Jump with jdata=0x000040 while buffer full and a read pending:
  - exe_flush=1 for exactly 1 cycle;
  - stale returned word dropped;
  - next imem_addr=0x40;
  - first valid instr=0x1040, 3 cycles after jump.
- PC preloaded to 0xFFFFFF via jump in IDLE, then start:
  - imem_addr 0xFFFFFF then 0x000000;
  - no exe_flush pulse from the IDLE jump.
- halt while running with 2 buffered words and next_instr=1:
  - no further imem_rd;
  - both buffered words delivered, plus the in-flight one;
  - busy falls once empty;
  - a later start resumes at the next sequential PC.
- rst asserted mid-stream with rd_pend=1:
  - next cycle valid=0, PC=0, imem_rd=0, exe_flush=0;
  - returned data ignored.
